// File: rtl/coherence_controller.sv
// coherence_controller: dual-core MSI snooping responder arbitrating I$/D$ traffic onto one RAM port.
// Define ARB_RR_EN for round-robin arbitration between cores; otherwise core 0 wins ties.
module coherence_controller #(
  parameter int CPUS = 2,
  parameter int BLK_WDS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [1:0]      iREN,
  input  logic [1:0][31:0] iaddr,
  input  logic [1:0]      dREN,
  input  logic [1:0]      dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]      ccwrite,
  input  logic [1:0]      cctrans,
  input  logic [31:0]     ramload,
  input  logic [1:0]      ramstate,
  output logic [1:0]      iwait,
  output logic [1:0]      dwait,
  output logic [1:0][31:0] iload,
  output logic [1:0][31:0] dload,
  output logic [1:0]      ccwait,
  output logic [1:0]      ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic            ramREN,
  output logic            ramWEN,
  output logic [31:0]     ramaddr,
  output logic [31:0]     ramstore
);
  typedef enum logic [2:0] {IDLE, WB, SNOOP, INVAL, C2C, LOAD, IFETCH} state_t;
  localparam int W = $clog2(BLK_WDS) + 1;
  localparam logic [1:0] CM = CPUS > 1 ? 2'b11 : 2'b01;
  state_t state;
  logic req, s, acc, fin, g;
  logic [W-1:0] wcnt;
  logic [1:0] dq, iq, cls;
  assign s = ~req;
  assign acc = ramstate == 2'b10;
  assign fin = acc && wcnt == W'(BLK_WDS - 1);
  // D$ traffic of either core outranks any I$ fetch
  assign dq = (dWEN | (cctrans & dREN) | (cctrans & ccwrite & ~dREN)) & CM;
  assign iq = iREN & CM;
  assign cls = |dq ? dq : iq;
`ifdef ARB_RR_EN
  logic last, done;
  assign g = &cls ? ~last : ~cls[0];
  assign done = state == INVAL || (state == IFETCH && acc) || (fin && state inside {WB, C2C, LOAD});
`else
  assign g = ~cls[0];
`endif
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      req <= 1'b0;
      wcnt <= '0;
`ifdef ARB_RR_EN
      last <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (|cls) begin
          req <= g;
          state <= dWEN[g] ? WB : cctrans[g] & dREN[g] ? SNOOP : cctrans[g] & ccwrite[g] ? INVAL : IFETCH;
        end
        WB, C2C, LOAD: if (acc) begin
          wcnt <= fin ? '0 : wcnt + 1'b1;
          if (fin) state <= IDLE;
        end
        SNOOP: state <= dWEN[s] & CM[s] ? C2C : LOAD;
        INVAL: state <= IDLE;
        IFETCH: if (acc) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef ARB_RR_EN
      if (done) last <= req;
`endif
    end
  end
  always_comb begin
    iwait = 2'b11;
    dwait = 2'b11;
    iload = '0;
    dload = '0;
    ccwait = 2'b00;
    ccinv = 2'b00;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    case (state)
      WB: begin
        ramWEN = 1'b1;
        ramaddr = daddr[req];
        ramstore = dstore[req];
        dwait[req] = ~acc;
      end
      SNOOP: begin
        ccwait[s] = 1'b1;
        ccinv[s] = ccwrite[req];
        ccsnoopaddr[s] = daddr[req];
      end
      C2C: begin
        ccwait[s] = 1'b1;
        ramWEN = 1'b1;
        ramaddr = daddr[s];
        ramstore = dstore[s];
        dload[req] = dstore[s];
        dwait[req] = ~acc;
        dwait[s] = ~acc;
      end
      LOAD: begin
        ccwait[s] = 1'b1;
        ramREN = 1'b1;
        ramaddr = daddr[req];
        dload[req] = ramload;
        dwait[req] = ~acc;
      end
      INVAL: begin
        ccwait[s] = 1'b1;
        ccinv[s] = 1'b1;
        ccsnoopaddr[s] = daddr[req];
      end
      IFETCH: begin
        ramREN = 1'b1;
        ramaddr = iaddr[req];
        iload[req] = ramload;
        iwait[req] = ~acc;
      end
      default: ;
    endcase
    if (CPUS < 2) begin
      iwait[1] = 1'b1;
      dwait[1] = 1'b1;
      iload[1] = '0;
      dload[1] = '0;
      ccwait[1] = 1'b0;
      ccinv[1] = 1'b0;
      ccsnoopaddr[1] = '0;
    end
  end
endmodule
